// File: rtl/axil_cmd_master_pkg.sv
// Shared AXI4-Lite definitions: response codes, command-master FSM states
// and the register map of the attached register slave.
package axil_cmd_master_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [15:0] REG_CTRL   = 16'h0000;
   localparam logic [15:0] REG_STATUS = 16'h0004;
   localparam logic [15:0] REG_DATA   = 16'h0008;
   localparam logic [15:0] REG_ID     = 16'h000C;

   localparam int CYC_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_RSP     = 3'd5
   } state_e;

   function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
      return (v == {CYC_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite single-outstanding command master: one command in, one AW+W/B
// or AR/R exchange out, one response back with a latency count.
module axil_cmd_master
   import axil_cmd_master_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 16,
   parameter int C_M_AXI_DATA_WIDTH = 32
) (
   input  logic                            M_AXI_ACLK,
   input  logic                            M_AXI_ARESETN,
   input  logic                            cmd_valid_i,
   output logic                            cmd_ready_o,
   input  logic                            cmd_write_i,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata_i,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb_i,
   output logic                            rsp_valid_o,
   input  logic                            rsp_ready_i,
   output logic                            rsp_write_o,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic [1:0]                      rsp_resp_o,
   output logic [CYC_W-1:0]                rsp_cycles_o,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int SW = C_M_AXI_DATA_WIDTH / 8;

   state_e state_q, state_d;

   logic          init_q, init_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [SW-1:0] wstrb_q, wstrb_d;
   logic          awvalid_q, awvalid_d;
   logic          wvalid_q, wvalid_d;
   logic          rsp_write_q, rsp_write_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [1:0]    resp_q, resp_d;
   logic [CYC_W-1:0] cnt_q, cnt_d;

   logic accept;
   logic aw_done;
   logic w_done;

   assign accept  = cmd_valid_i && cmd_ready_o;
   assign aw_done = !awvalid_q || M_AXI_AWREADY;
   assign w_done  = !wvalid_q || M_AXI_WREADY;

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = cmd_write_i ? ST_WR_REQ : ST_RD_REQ;
            end
         end
         ST_WR_REQ: begin
            if (aw_done && w_done) state_d = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            if (M_AXI_BVALID) state_d = ST_RSP;
         end
         ST_RD_REQ: begin
            if (M_AXI_ARREADY) state_d = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            if (M_AXI_RVALID) state_d = ST_RSP;
         end
         ST_RSP: begin
            if (rsp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // init_q holds cmd_ready_o low until the first clock after reset release.
   always_comb begin
      cmd_ready_o   = (state_q == ST_IDLE) && init_q;
      M_AXI_ARVALID = (state_q == ST_RD_REQ);
      M_AXI_BREADY  = (state_q == ST_WR_RESP);
      M_AXI_RREADY  = (state_q == ST_RD_DATA);
      rsp_valid_o   = (state_q == ST_RSP);
   end

   always_comb begin
      init_d      = 1'b1;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      rsp_write_d = rsp_write_q;
      rdata_d     = rdata_q;
      resp_d      = resp_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d      = cmd_addr_i;
               wdata_d     = cmd_wdata_i;
               wstrb_d     = cmd_wstrb_i;
               awvalid_d   = cmd_write_i;
               wvalid_d    = cmd_write_i;
               rsp_write_d = cmd_write_i;
               cnt_d       = '0;
            end
         end
         ST_WR_REQ: begin
            cnt_d = sat_inc(cnt_q);
            if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
            if (wvalid_q && M_AXI_WREADY) wvalid_d = 1'b0;
         end
         ST_WR_RESP: begin
            cnt_d = sat_inc(cnt_q);
            if (M_AXI_BVALID) begin
               resp_d  = M_AXI_BRESP;
               rdata_d = '0;
            end
         end
         ST_RD_REQ: begin
            cnt_d = sat_inc(cnt_q);
         end
         ST_RD_DATA: begin
            cnt_d = sat_inc(cnt_q);
            if (M_AXI_RVALID) begin
               resp_d  = M_AXI_RRESP;
               rdata_d = M_AXI_RDATA;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         init_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         rsp_write_q <= 1'b0;
         rdata_q     <= '0;
         resp_q      <= '0;
         cnt_q       <= '0;
      end else begin
         init_q      <= init_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         rsp_write_q <= rsp_write_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
         cnt_q       <= cnt_d;
      end
   end

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;

   assign rsp_write_o  = rsp_write_q;
   assign rsp_rdata_o  = rdata_q;
   assign rsp_resp_o   = resp_q;
   assign rsp_cycles_o = cnt_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: delay-programmable AXI-Lite slave plus a
// per-transaction expectation derived from the programmed slave delays.
module tb_axil_cmd_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
   logic [15:0] cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   logic [3:0]  cmd_wstrb_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_write_o;
   logic [31:0] rsp_rdata_o;
   logic [1:0]  rsp_resp_o;
   logic [15:0] rsp_cycles_o;
   logic [15:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        bvalid, bready, arvalid, arready, rvalid, rready;

   axil_cmd_master dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
      .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_write_o(rsp_write_o), .rsp_rdata_o(rsp_rdata_o),
      .rsp_resp_o(rsp_resp_o), .rsp_cycles_o(rsp_cycles_o),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
      .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
      .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // slave programming for the current transaction
   int          cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
   logic [1:0]  cfg_resp;
   logic [31:0] cfg_rdata;
   logic [15:0] exp_addr;
   logic [31:0] exp_wdata;
   logic [3:0]  exp_wstrb;
   int aw_hs, w_hs, b_hs, ar_hs, r_hs;

   int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   logic aw_was, aw_rdy_was, w_was, w_rdy_was, ar_was, ar_rdy_was;

   initial begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rresp = 0; rdata = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_was = 0; aw_rdy_was = 0; w_was = 0; w_rdy_was = 0;
      ar_was = 0; ar_rdy_was = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0;
            arready = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_was = 0; aw_rdy_was = 0; w_was = 0; w_rdy_was = 0;
            ar_was = 0; ar_rdy_was = 0;
         end else begin
            if (aw_was && !aw_rdy_was) chk("aw_hold", awvalid, 1);
            if (w_was && !w_rdy_was) chk("w_hold", wvalid, 1);
            if (ar_was && !ar_rdy_was) chk("ar_hold", arvalid, 1);
            if (awvalid) begin
               chk("awaddr", awaddr, exp_addr);
               chk("awprot", awprot, 0);
               awready = (aw_cnt >= cfg_aw);
               aw_cnt++;
               if (awready) aw_hs++;
            end else begin
               awready = 0; aw_cnt = 0;
            end
            if (wvalid) begin
               chk("wdata", wdata, exp_wdata);
               chk("wstrb", wstrb, exp_wstrb);
               wready = (w_cnt >= cfg_w);
               w_cnt++;
               if (wready) w_hs++;
            end else begin
               wready = 0; w_cnt = 0;
            end
            if (arvalid) begin
               if (ar_cnt < 4) chk("araddr", araddr, exp_addr);
               if (ar_cnt == 0) chk("arprot", arprot, 0);
               arready = (ar_cnt >= cfg_ar);
               ar_cnt++;
               if (arready) ar_hs++;
            end else begin
               arready = 0; ar_cnt = 0;
            end
            if (bready) begin
               bvalid = (b_cnt >= cfg_b);
               bresp = bvalid ? cfg_resp : 2'($urandom);
               b_cnt++;
               if (bvalid) b_hs++;
            end else begin
               bvalid = 0; b_cnt = 0;
            end
            if (rready) begin
               rvalid = (r_cnt >= cfg_r);
               rdata = rvalid ? cfg_rdata : $urandom;
               rresp = rvalid ? cfg_resp : 2'($urandom);
               r_cnt++;
               if (rvalid) r_hs++;
            end else begin
               rvalid = 0; r_cnt = 0;
            end
            aw_was = awvalid; aw_rdy_was = awready;
            w_was = wvalid; w_rdy_was = wready;
            ar_was = arvalid; ar_rdy_was = arready;
         end
      end
   end

   task automatic issue(input bit wr, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output bit ok);
      int n;
      ok = 0;
      exp_addr = a; exp_wdata = d; exp_wstrb = s;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      n = 0;
      @(negedge clk);
      while (!cmd_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready_o) begin
         chk("cmd_ready_wait", cmd_ready_o, 1);
      end else begin
         cmd_valid_i = 1; cmd_write_i = wr;
         cmd_addr_i = a; cmd_wdata_i = d; cmd_wstrb_i = s;
         @(posedge clk);
         #1;
         cmd_valid_i = 0;
         cmd_write_i = 1'($urandom);
         cmd_addr_i = 16'($urandom);
         cmd_wdata_i = $urandom;
         cmd_wstrb_i = 4'($urandom);
         chk("cmd_ready_busy", cmd_ready_o, 0);
         ok = 1;
      end
   endtask

   task automatic run_txn(input bit wr, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input int hold, input int bound);
      bit ok;
      int n, ecyc;
      logic [31:0] erd;
      issue(wr, a, d, s, ok);
      if (ok) begin
         n = 0;
         @(negedge clk);
         while (!rsp_valid_o && n < bound) begin
            @(negedge clk);
            n++;
         end
         if (!rsp_valid_o) begin
            chk("rsp_timeout", rsp_valid_o, 1);
         end else begin
            if (wr) ecyc = ((cfg_aw > cfg_w) ? cfg_aw : cfg_w) + cfg_b + 2;
            else ecyc = cfg_ar + cfg_r + 2;
            if (ecyc > 65535) ecyc = 65535;
            erd = wr ? 32'h0 : cfg_rdata;
            chk("hs_aw", aw_hs, wr ? 1 : 0);
            chk("hs_w", w_hs, wr ? 1 : 0);
            chk("hs_b", b_hs, wr ? 1 : 0);
            chk("hs_ar", ar_hs, wr ? 0 : 1);
            chk("hs_r", r_hs, wr ? 0 : 1);
            for (int i = 0; i <= hold; i++) begin
               if (i > 0) @(negedge clk);
               chk("rsp_valid", rsp_valid_o, 1);
               chk("rsp_write", rsp_write_o, wr);
               chk("rsp_rdata", rsp_rdata_o, erd);
               chk("rsp_resp", rsp_resp_o, cfg_resp);
               chk("rsp_cycles", rsp_cycles_o, ecyc);
               chk("cmd_ready_rsp", cmd_ready_o, 0);
            end
            rsp_ready_i = 1;
            @(posedge clk);
            #1;
            rsp_ready_i = 0;
            chk("rsp_done", rsp_valid_o, 0);
            chk("idle_ready", cmd_ready_o, 1);
         end
      end
   endtask

   task automatic set_slave(input int aw, input int w, input int b,
                            input int ar, input int r,
                            input logic [1:0] rs, input logic [31:0] rd);
      cfg_aw = aw; cfg_w = w; cfg_b = b; cfg_ar = ar; cfg_r = r;
      cfg_resp = rs; cfg_rdata = rd;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_awvalid"}, awvalid, 0);
      chk({tag, "_wvalid"}, wvalid, 0);
      chk({tag, "_arvalid"}, arvalid, 0);
      chk({tag, "_bready"}, bready, 0);
      chk({tag, "_rready"}, rready, 0);
      chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
      chk({tag, "_cmd_ready"}, cmd_ready_o, 0);
   endtask

   task automatic reset_mid_write();
      bit ok;
      int n;
      set_slave(0, 0, 30, 0, 0, 2'b00, 0);
      issue(1, 16'h0010, 32'hCAFE_F00D, 4'hF, ok);
      n = 0;
      @(negedge clk);
      while (!bready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach_wr_resp", bready, 1);
      rst_n = 0;
      #1;
      chk_quiet("rst_mid");
      chk("rst_mid_cycles", rsp_cycles_o, 0);
      chk("rst_mid_resp", rsp_resp_o, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_hold_rsp", rsp_valid_o, 0);
      end
      rst_n = 1;
      #1;
      chk("rel_cmd_ready_lo", cmd_ready_o, 0);
      @(posedge clk);
      #1;
      chk("rel_cmd_ready_hi", cmd_ready_o, 1);
      chk("rel_no_rsp", rsp_valid_o, 0);
      chk("rel_b_hs", b_hs, 0);
   endtask

   initial begin
      rst_n = 0;
      cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = 0;
      cmd_wdata_i = 0; cmd_wstrb_i = 0; rsp_ready_i = 0;
      set_slave(0, 0, 0, 0, 0, 2'b00, 0);
      exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
      repeat (3) @(negedge clk);
      chk_quiet("reset");
      chk("reset_rsp_write", rsp_write_o, 0);
      chk("reset_rsp_rdata", rsp_rdata_o, 0);
      chk("reset_rsp_resp", rsp_resp_o, 0);
      chk("reset_rsp_cycles", rsp_cycles_o, 0);
      rst_n = 1;

      set_slave(0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF);
      run_txn(1, 16'h0000, 32'h0000_0003, 4'hF, 0, 50);
      set_slave(0, 0, 0, 0, 5, 2'b00, 32'h1234_5678);
      run_txn(0, 16'h0008, 32'h0, 4'h0, 0, 50);
      set_slave(3, 0, 0, 0, 0, 2'b00, 0);
      run_txn(1, 16'h0004, 32'hA5A5_0001, 4'h3, 0, 50);
      set_slave(0, 4, 1, 0, 0, 2'b11, 0);
      run_txn(1, 16'h000C, 32'h0F0F_F0F0, 4'h8, 1, 50);
      set_slave(0, 0, 0, 0, 2, 2'b10, 32'h0BAD_0BAD);
      run_txn(0, 16'h0004, 32'h0, 4'h0, 4, 50);
      set_slave(0, 0, 0, 70000, 0, 2'b01, 32'h7777_0000);
      run_txn(0, 16'h00F0, 32'h0, 4'h0, 0, 80000);

      for (int t = 0; t < 40; t++) begin
         set_slave($urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 4), 2'($urandom_range(0, 3)),
                   $urandom);
         run_txn(1'($urandom), 16'($urandom) & 16'hFFFC, $urandom,
                 4'($urandom), $urandom_range(0, 3), 100);
      end

      reset_mid_write();
      set_slave(1, 2, 0, 0, 0, 2'b00, 0);
      run_txn(1, 16'h0020, 32'h5555_AAAA, 4'hF, 0, 50);
      set_slave(0, 0, 0, 1, 1, 2'b00, 32'h89AB_CDEF);
      run_txn(0, 16'h0024, 32'h0, 4'h0, 2, 50);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
